// File: rtl/gate_arb_pkg.sv
// Shared types and default parameters for the gate-sharing arbiter.
package gate_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_DEF      = 3;
    localparam int W_DEF      = 3;
    localparam int R_DEF      = 1;
    localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/gate_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, modulo N.
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] index,
    output logic          valid
);

    int j;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                winner[j] = 1'b1;
                index     = PW'(j);
            end
        end
    end

endmodule

// File: rtl/gate_share_arbiter.sv
// Shares one fixed-delay gate unit among N requesters: grant, hold operands
// for SETTLE cycles, capture the unit output and pulse done to the owner.
//
//  state | meaning
//  IDLE  | no owner; arbitrate among active requests
//  DRIVE | operands held on unit_in while the gate settles
//  DONE  | result valid, done pulses to the owner for one cycle
module gate_share_arbiter
    import gate_arb_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int W      = W_DEF,
    parameter int R      = R_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_data,
    output logic [W-1:0]   unit_in,
    input  logic [R-1:0]   unit_out,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic [R-1:0]   result,
    output logic           busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    win_onehot;
    logic [PW-1:0]   win_idx;
    logic            win_valid;

    rr_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (win_onehot),
        .index  (win_idx),
        .valid  (win_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            cnt     <= '0;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
            result  <= '0;
            unit_in <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant   <= win_onehot;
                        unit_in <= req_data[win_idx*W +: W];
                        cnt     <= CW'(SETTLE - 1);
                        busy    <= 1'b1;
                        state   <= DRIVE;
                        rr_ptr  <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                DRIVE: begin
                    // Counter reaching zero means the gate has had SETTLE cycles.
                    if (cnt == '0) begin
                        result <= unit_out;
                        done   <= grant;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_share_arbiter.md
# gate_share_arbiter

Round-robin arbiter and sequencer that shares one delayed combinational gate unit (a delayed 3-input AND or any gate network with fixed propagation delay) among N requesters. It grants the unit to one requester at a time and drives that requester's operand vector onto the unit inputs. It then waits a fixed number of settle cycles covering the gate propagation delay, captures the unit output and returns it with a one-cycle done pulse. It sits between the requesting control logic and the shared gate-level datapath.

## Interface
- N, default 3: number of requesters (≥2).
- W, default 3: operand width driven to the unit (one bit per gate input).
- R, default 1: unit output width.
- SETTLE, default 2: cycles the unit inputs are held before capture. Must be ≥1. Set to ceil(gate delay / clock period).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- req  input  N  per-requester request level.
- req_data  input  N*W  flattened operands; requester i occupies bits [i*W +: W].
- unit_in  output  W  operands driven to the shared gate unit.
- unit_out  input  R  gate unit output.
- grant  output  N  one-hot owner of the unit; all-zero when idle.
- done  output  N  one-cycle pulse to the owner when result is valid.
- result  output  R  captured unit output, shared by all requesters.
- busy  output  1  high in DRIVE and DONE.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - If any req bit is set, pick the winner round-robin, starting the search at pointer rr_ptr.
  - Register the winner: grant goes one-hot, unit_in latches the winner's req_data, the settle counter loads SETTLE-1, and the state moves to DRIVE.
  - Set rr_ptr to winner+1, wrapping at N to 0.
  - If no req bit is set, stay in IDLE with grant=0.
- DRIVE:
  - unit_in and grant are held constant.
  - The counter decrements each cycle.
  - When the counter is 0, capture unit_out into result and go to DONE.
- DONE:
  - done[owner]=1 for exactly one cycle; grant is still asserted.
  - Next state is IDLE, where grant clears.
- unit_in is a registered copy of req_data. Changes to req_data after the grant are ignored.
- Dropping req during DRIVE or DONE does not abort the operation. done still pulses and result still updates.
- A requester holding req high after done re-enters arbitration in the following IDLE cycle at its round-robin priority.
- result holds its last value until the next capture. unit_in holds its last value in IDLE.
- Reset values: grant=0, done=0, busy=0, result=0, unit_in=0, rr_ptr=0, state=IDLE, counter=0.
- Reset asserted in any state takes effect at the next clock edge. The in-flight operation is discarded and no done is issued.

## Timing
- Let req be sampled high in IDLE at edge t:
  - grant and unit_in are valid from cycle t+1.
  - DRIVE occupies cycles t+1 … t+SETTLE.
  - result is captured at the edge ending cycle t+SETTLE.
  - done and the new result are visible in cycle t+SETTLE+1.
- Throughput: one operation per SETTLE+2 cycles; the extra cycles are DONE and IDLE.
- With simultaneous requests, the lowest index at or after rr_ptr (modulo N) wins.
- grant is always zero or one-hot; no combinational path from req to grant.

## Structure
- Shared package gate_arb_pkg:
  - state enum {IDLE, DRIVE, DONE};
  - default constants N_DEF=3, W_DEF=3, R_DEF=1, SETTLE_DEF=2.
- Counter width: $clog2(SETTLE+1).
- Sub-module rr_picker (combinational):
  - inputs req[N-1:0] and ptr;
  - outputs a one-hot winner and its index.
  - Instantiated once; all state lives in gate_share_arbiter.

## Test plan
All scenarios use N=3, W=3, R=1, SETTLE=2, with a behavioural unit model: unit_out = &unit_in, updated after a 1-cycle delay.
- Reset: hold rst_n=0 for 2 cycles with req=3'b111 → grant=0, done=0, busy=0, result=0, unit_in=0 throughout.
- Single request: req=3'b010 with operand 3'b111 at edge t →
  - grant=3'b010 and unit_in=3'b111 in cycles t+1..t+3;
  - done=3'b010 and result=1 in cycle t+3 only;
  - grant=0 at t+4.
  - Repeat with operand 3'b101 → result=0.
- Full contention: req=3'b111 held high → grants in order 001, 010, 100, 001, with successive grants spaced 4 cycles apart.
- Partial contention: req=3'b101 held high → grants alternate 001, 100, 001; requester 1 is never granted.
- Request drop: requester 0 deasserts req in the first DRIVE cycle and changes its req_data → unit_in is unchanged, done[0] still pulses at the scheduled cycle, and result matches the original operand.
- Reset mid-operation: assert rst_n=0 in the second DRIVE cycle → next cycle grant=0 and busy=0, no done pulse, result=0. The first grant after reset goes to the lowest requesting index (rr_ptr=0).
